// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single off-chip memory port between the I-cache and the D-cache.
// The I-cache only issues block reads. The D-cache issues block reads and write-backs.
// When both caches request in the same cycle, the grant alternates between them.
// Only one memory transaction is in flight at a time.
// The winner's address, data and operation are latched at the grant edge.
// Read data is returned with a one-cycle ready pulse.
// Every output comes from a flop, so no input reaches an output combinationally.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | no transaction; arbitrate between requesters
//  S_I_MEM  | I-cache read on the memory port, waiting for mem_ready
//  S_D_MEM  | D-cache read or write on the memory port, waiting for mem_ready
//  S_I_RESP | i_ready pulse; requests are not evaluated here
//  S_D_RESP | d_ready pulse; requests are not evaluated here

module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I_MEM  = 3'd1,
        S_D_MEM  = 3'd2,
        S_I_RESP = 3'd3,
        S_D_RESP = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // r_last_d: 1 when the D-cache holds the most recent grant; resets to I
    logic                r_last_d;
    logic                r_op_write;

    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_ready;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_busy;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_op_write_nxt;
    logic                w_mem_read_nxt;
    logic                w_mem_write_nxt;
    logic                w_i_ready_nxt;
    logic                w_d_ready_nxt;
    logic                w_busy_nxt;

    // Arbitration: only in IDLE; on a tie the side that did not win last time is granted
    always_comb begin
        w_i_req   = i_read;
        w_d_req   = d_read | d_write;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_i_req && w_d_req) begin
                w_grant_d = ~r_last_d;
                w_grant_i = r_last_d;
            end else begin
                w_grant_i = w_i_req;
                w_grant_d = w_d_req;
            end
        end
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_D_MEM;
                end else if (w_grant_i) begin
                    w_state_nxt = S_I_MEM;
                end
            end
            S_I_MEM: begin
                if (mem_ready) begin
                    w_state_nxt = S_I_RESP;
                end
            end
            S_D_MEM: begin
                if (mem_ready) begin
                    w_state_nxt = S_D_RESP;
                end
            end
            S_I_RESP: w_state_nxt = S_IDLE;
            S_D_RESP: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the flops present outputs in step with the state
    always_comb begin
        // A D grant with both d_read and d_write high becomes a write
        w_op_write_nxt  = w_grant_d ? d_write : r_op_write;
        w_mem_read_nxt  = (w_state_nxt == S_I_MEM) ||
                          ((w_state_nxt == S_D_MEM) && !w_op_write_nxt);
        w_mem_write_nxt = (w_state_nxt == S_D_MEM) && w_op_write_nxt;
        w_i_ready_nxt   = (w_state_nxt == S_I_RESP);
        w_d_ready_nxt   = (w_state_nxt == S_D_RESP);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // Registered strobes, ready pulses and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_i_ready   <= w_i_ready_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Latch the winner's request at the grant edge and remember who won
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d    <= 1'b0;
            r_op_write  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_last_d    <= 1'b1;
            r_op_write  <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_last_d    <= 1'b0;
            r_op_write  <= 1'b0;
            r_mem_addr  <= i_addr;
        end
    end

    // Capture read data on mem_ready; a D-cache write-back leaves d_rdata alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if ((r_state == S_I_MEM) && mem_ready) begin
                r_i_rdata <= mem_rdata;
            end
            if ((r_state == S_D_MEM) && mem_ready && !r_op_write) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// A table of request patterns is applied to the DUT.
// For each pattern, a round-robin model decides the expected service order.
// The expected transactions are pushed to a queue in that order.
// When a memory strobe appears, the next expected transaction is popped and compared.
// Hand-written sequences cover reset during a transaction, zero-wait memory
// and an address that changes while its requester waits.

module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              is_d;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    typedef struct {
        bit                ri;
        bit                rd;
        bit                dw;
        bit                drop;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [DATA_W-1:0] wd;
        int                lat;
    } vec_t;

    txn_t              exp_q[$];
    vec_t              vt[8];
    int                n_cmp;
    int                n_bad;
    logic              model_last_d;
    logic [DATA_W-1:0] exp_i_rdata;
    logic [DATA_W-1:0] exp_d_rdata;

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return {32'hDEADBEEF, 4'h0, a, 64'h0123_4567_89AB_CDEF ^ {36'h0, a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drop_req(input logic is_d);
        if (is_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    // Wait for the next memory transaction, check it against the scoreboard,
    // respond after lat wait cycles and check the ready pulse that follows.
    task automatic serve(input int lat, input bit drop_early, input bit chg_other,
                         input logic [ADDR_W-1:0] other_addr);
        txn_t              e;
        int                n;
        logic [DATA_W-1:0] rd;
        n = 0;
        while (!(mem_read || mem_write) && n < 40) begin
            tick();
            n++;
        end
        if (!(mem_read || mem_write)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL serve_timeout: no memory strobe within 40 cycles (t=%0t)", $time);
            return;
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: strobe seen with empty scoreboard (t=%0t)", $time);
            return;
        end
        e = exp_q.pop_front();
        chk1("mem_write_op", mem_write, e.wr);
        chk1("mem_read_op", mem_read, ~e.wr);
        chkw("mem_addr", 128'(mem_addr), 128'(e.addr));
        if (e.wr) chkw("mem_wdata", mem_wdata, e.wdata);
        chk1("busy_in_mem", busy, 1'b1);
        // The granted side's inputs no longer matter; scramble them
        if (e.is_d) begin
            d_addr  = ~e.addr;
            d_wdata = ~e.wdata;
        end else begin
            i_addr = ~e.addr;
        end
        if (chg_other) begin
            if (e.is_d) i_addr = other_addr;
            else        d_addr = other_addr;
        end
        if (drop_early) drop_req(e.is_d);
        for (int k = 0; k < lat; k++) begin
            tick();
            chk1("strobe_held", mem_read | mem_write, 1'b1);
            chkw("addr_held", 128'(mem_addr), 128'(e.addr));
            if (e.wr) chkw("wdata_held", mem_wdata, e.wdata);
        end
        rd        = mem_data(e.addr);
        mem_ready = 1'b1;
        mem_rdata = e.wr ? 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0 : rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (!e.wr) begin
            if (e.is_d) exp_d_rdata = rd;
            else        exp_i_rdata = rd;
        end
        chk1("i_ready_pulse", i_ready, ~e.is_d);
        chk1("d_ready_pulse", d_ready, e.is_d);
        chk1("mem_read_low_resp", mem_read, 1'b0);
        chk1("mem_write_low_resp", mem_write, 1'b0);
        chkw("i_rdata", i_rdata, exp_i_rdata);
        chkw("d_rdata", d_rdata, exp_d_rdata);
        drop_req(e.is_d);
        tick();
        chk1("i_ready_one_cycle", i_ready, 1'b0);
        chk1("d_ready_one_cycle", d_ready, 1'b0);
    endtask

    function automatic txn_t mk_txn(input logic is_d, input vec_t v);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = is_d ? v.dw : 1'b0;
        t.addr  = is_d ? v.da : v.ia;
        t.wdata = is_d ? v.wd : '0;
        return t;
    endfunction

    task automatic apply_vec(input vec_t v);
        logic first_d;
        i_addr  = v.ia;
        d_addr  = v.da;
        d_wdata = v.wd;
        if (v.ri && (v.rd || v.dw)) begin
            first_d = ~model_last_d;
            exp_q.push_back(mk_txn(first_d, v));
            exp_q.push_back(mk_txn(~first_d, v));
            model_last_d = ~first_d;
        end else if (v.ri) begin
            exp_q.push_back(mk_txn(1'b0, v));
            model_last_d = 1'b0;
        end else begin
            exp_q.push_back(mk_txn(1'b1, v));
            model_last_d = 1'b1;
        end
        i_read  = v.ri;
        d_read  = v.rd;
        d_write = v.dw;
        serve(v.lat, v.drop, 1'b0, '0);
        if (v.ri && (v.rd || v.dw)) serve(v.lat, v.drop, 1'b0, '0);
        chk1("busy_idle_after", busy, 1'b0);
        chkw("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pulses;
        int   last_c;
        int   strobes;
        int   n;
        vec_t v;

        n_cmp        = 0;
        n_bad        = 0;
        model_last_d = 1'b0;
        exp_i_rdata  = '0;
        exp_d_rdata  = '0;

        rst_n     = 1'b0;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        vt[0] = '{ri:1, rd:1, dw:0, drop:0, ia:28'h0000100, da:28'h0000200, wd:'0, lat:2};
        vt[1] = '{ri:0, rd:1, dw:0, drop:0, ia:28'h0, da:28'h0000300, wd:'0, lat:1};
        vt[2] = '{ri:1, rd:1, dw:0, drop:0, ia:28'h0000140, da:28'h0000240, wd:'0, lat:1};
        vt[3] = '{ri:1, rd:0, dw:0, drop:0, ia:28'h0000040, da:28'h0, wd:'0, lat:4};
        vt[4] = '{ri:0, rd:0, dw:1, drop:0, ia:28'h0, da:28'h0000080,
                  wd:128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, lat:3};
        vt[5] = '{ri:0, rd:1, dw:1, drop:1, ia:28'h0, da:28'h00000C0,
                  wd:128'hCAFEF00D_00000000_FFFFFFFF_A5A5A5A5, lat:0};
        vt[6] = '{ri:1, rd:0, dw:0, drop:1, ia:28'hFFFFFFF, da:28'h0, wd:'0, lat:0};
        vt[7] = '{ri:1, rd:0, dw:1, drop:0, ia:28'h0000500, da:28'h0000600,
                  wd:128'h0F0F0F0F_F0F0F0F0_11111111_22222222, lat:5};

        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chkw("rst_mem_addr", 128'(mem_addr), 128'(0));
        chkw("rst_mem_wdata", mem_wdata, '0);
        chkw("rst_i_rdata", i_rdata, '0);
        chkw("rst_d_rdata", d_rdata, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) apply_vec(vt[i]);

        // Reset in the middle of a D write abandons it with all outputs cleared at once
        d_addr  = 28'h0000700;
        d_wdata = 128'h77777777_77777777_77777777_77777777;
        d_write = 1'b1;
        n = 0;
        while (!mem_write && n < 20) begin
            tick();
            n++;
        end
        chk1("mid_rst_write_started", mem_write, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_mem_write", mem_write, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chkw("mid_rst_mem_addr", 128'(mem_addr), 128'(0));
        chkw("mid_rst_mem_wdata", mem_wdata, '0);
        chkw("mid_rst_i_rdata", i_rdata, '0);
        chkw("mid_rst_d_rdata", d_rdata, '0);
        d_write      = 1'b0;
        model_last_d = 1'b0;
        exp_i_rdata  = '0;
        exp_d_rdata  = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk1("post_rst_no_ready", d_ready, 1'b0);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        tick();
        chk1("idle_mr_busy", busy, 1'b0);
        chk1("idle_mr_i_ready", i_ready, 1'b0);
        chk1("idle_mr_d_ready", d_ready, 1'b0);
        tick();
        chk1("idle_mr_busy2", busy, 1'b0);
        mem_ready = 1'b0;

        // First tie after reset must go to D
        v = '{ri:1, rd:1, dw:0, drop:0, ia:28'h0000800, da:28'h0000900, wd:'0, lat:1};
        apply_vec(v);

        // I waits behind D while its address changes; its grant uses the new address
        v = '{ri:1, rd:0, dw:0, drop:0, ia:28'h0000A00, da:28'h0, wd:'0, lat:0};
        apply_vec(v);
        i_addr  = 28'h0000B00;
        d_addr  = 28'h0000C00;
        exp_q.push_back('{is_d:1'b1, wr:1'b0, addr:28'h0000C00, wdata:'0});
        exp_q.push_back('{is_d:1'b0, wr:1'b0, addr:28'h0000D00, wdata:'0});
        model_last_d = 1'b0;
        i_read = 1'b1;
        d_read = 1'b1;
        serve(2, 1'b0, 1'b1, 28'h0000D00);
        serve(1, 1'b0, 1'b0, '0);
        chkw("addr_change_queue_empty", 128'(exp_q.size()), 128'(0));

        // Zero-wait memory with D read held: ready every 3 cycles, one strobe per ready
        d_addr    = 28'h0ABCDE0;
        d_read    = 1'b1;
        mem_rdata = mem_data(28'h0ABCDE0);
        mem_ready = 1'b1;
        pulses    = 0;
        last_c    = -1;
        strobes   = 0;
        for (int c = 0; c < 40 && pulses < 4; c++) begin
            tick();
            if (mem_read || mem_write) strobes++;
            if (i_ready) chk1("zw_no_i_ready", i_ready, 1'b0);
            if (d_ready) begin
                chk1("zw_no_strobe_in_resp", mem_read | mem_write, 1'b0);
                chkw("zw_d_rdata", d_rdata, mem_data(28'h0ABCDE0));
                if (last_c >= 0) chkw("zw_interval", 128'(c - last_c), 128'(3));
                last_c = c;
                pulses++;
                if (pulses == 4) begin
                    d_read    = 1'b0;
                    mem_ready = 1'b0;
                end
            end
        end
        chkw("zw_pulses", 128'(pulses), 128'(4));
        chkw("zw_strobes", 128'(strobes), 128'(4));
        tick();
        chk1("zw_idle_after", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
